// File: rtl/mcu_timer.sv
// mcu_timer: 16-bit down-counting timer with an 8-bit prescaler, reload register,
// periodic or one-shot expiry, and a registered read snapshot.
// Ports: clk/rst (async, active-high); timer_cs gates timer_wr/timer_start/timer_rd;
//   timer_datain loads reload; timer_value = snapshot of count; timer_INT = 1-cycle expiry pulse.
module mcu_timer #(
  parameter int DIV         = 1,  // clk cycles per count tick, 1..256
  parameter int AUTO_RELOAD = 1   // 1 = periodic, 0 = one-shot
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_cs,
  input  logic        timer_wr,
  input  logic        timer_start,
  input  logic        timer_rd,
  input  logic [15:0] timer_datain,
  output logic [15:0] timer_value,
  output logic        timer_INT
);

  localparam logic [7:0] PRE_LAST = 8'(DIV - 1);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [15:0] reload;
  logic [15:0] count;
  logic [7:0]  presc;
  logic [1:0]  state;

  logic wr_en;
  logic rd_en;
  logic run_en;
  logic tick;

  always_comb begin
    wr_en  = timer_cs & timer_wr;
    rd_en  = timer_cs & timer_rd & ~wr_en;
    // Counting happens on the very edge that takes STOP to RUN, so the first
    // expiry lands (reload+1) ticks after start is first seen.
    run_en = timer_cs & timer_start & (state != ST_DONE);
    tick   = run_en & (presc == PRE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload      <= 16'd0;
      count       <= 16'd0;
      presc       <= 8'd0;
      state       <= ST_STOP;
      timer_value <= 16'd0;
      timer_INT   <= 1'b0;
    end else begin
      timer_INT <= 1'b0;

      if (rd_en) begin
        timer_value <= count;
      end

      if (wr_en) begin
        reload <= timer_datain;
        count  <= timer_datain;
        presc  <= 8'd0;
        state  <= ST_STOP;
      end else if (run_en) begin
        state <= ST_RUN;
        presc <= tick ? 8'd0 : presc + 8'd1;
        if (tick) begin
          if (count != 16'd0) begin
            count <= count - 16'd1;
          end else if (!timer_INT) begin
            // A tick arriving while the pulse is still high (DIV=1, reload=0)
            // does nothing, which keeps the pulse exactly one cycle wide.
            timer_INT <= 1'b1;
            count     <= reload;
            if (AUTO_RELOAD == 0) begin
              state <= ST_DONE;
            end
          end
        end
      end else if (state == ST_RUN) begin
        // Pause: count and prescaler are kept for a later resume.
        state <= ST_STOP;
      end
    end
  end

endmodule
